// File: rtl/input_conditioner_if.sv
// Bundle of the conditioner's control inputs, raw pad inputs and conditioned outputs.
// The driving frame uses master; the conditioner uses slave.
interface input_conditioner_if #(
    parameter int CHANNELS = 13
);
    logic                en;
    logic [CHANNELS-1:0] repeat_en;
    logic [CHANNELS-1:0] sig_i;
    logic [CHANNELS-1:0] sig_o;
    logic [CHANNELS-1:0] rise;
    logic [CHANNELS-1:0] fall;
    logic [CHANNELS-1:0] rpt;

    modport master (
        output en, repeat_en, sig_i,
        input  sig_o, rise, fall, rpt
    );

    modport slave (
        input  en, repeat_en, sig_i,
        output sig_o, rise, fall, rpt
    );
endinterface

// File: rtl/input_conditioner.sv
// N-channel pad conditioner: 2-FF sync, debounce, rise/fall pulses and key-repeat pulses.
//  state  | meaning
//  IDLE   | no press in progress, or repeat disabled since the last press
//  DELAY  | press seen, waiting RD_CYC enabled cycles for the first repeat
//  REPEAT | pulsing rpt every RR_CYC enabled cycles while the level stays high
module input_conditioner #(
    parameter int                  CHANNELS     = 13,
    parameter int                  CLK_FREQ     = 10,
    parameter int                  JITTER_MAX   = 10000,
    parameter int                  REPEAT_DELAY = 500000,
    parameter int                  REPEAT_RATE  = 100000,
    parameter logic [CHANNELS-1:0] INIT_LEVEL   = '0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input_conditioner_if.slave   bus
);
    localparam int JIT_CYC = CLK_FREQ * JITTER_MAX;
    localparam int RD_CYC  = CLK_FREQ * REPEAT_DELAY;
    localparam int RR_CYC  = CLK_FREQ * REPEAT_RATE;
    localparam int MAX_A   = (JIT_CYC > RD_CYC) ? JIT_CYC : RD_CYC;
    localparam int MAX_CYC = (MAX_A > RR_CYC) ? MAX_A : RR_CYC;
    localparam int CW      = $clog2(MAX_CYC + 1);

    // Compare against the value before the terminal count: the increment that
    // would reach the limit is the one that fires instead.
    localparam logic [CW-1:0] JIT_LAST = CW'(JIT_CYC - 1);
    localparam logic [CW-1:0] RD_LAST  = CW'(RD_CYC - 1);
    localparam logic [CW-1:0] RR_LAST  = CW'(RR_CYC - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        REPEAT = 2'd2
    } rpt_state_t;

    logic [CHANNELS-1:0] sync1;
    logic [CHANNELS-1:0] sync2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= INIT_LEVEL;
            sync2 <= INIT_LEVEL;
        end else begin
            sync1 <= bus.sig_i;
            sync2 <= sync1;
        end
    end

    for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_ch
        logic [CW-1:0] db_cnt;
        logic [CW-1:0] rp_cnt;
        logic          level_q;
        logic          rise_q;
        logic          fall_q;
        logic          rpt_q;
        logic          flip;
        rpt_state_t    state;

        assign flip = bus.en && (sync2[ch] != level_q) && (db_cnt == JIT_LAST);

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                db_cnt  <= '0;
                level_q <= INIT_LEVEL[ch];
                rise_q  <= 1'b0;
                fall_q  <= 1'b0;
            end else begin
                rise_q <= flip && !level_q;
                fall_q <= flip && level_q;
                if (bus.en) begin
                    if (sync2[ch] == level_q) begin
                        db_cnt <= '0;
                    end else if (flip) begin
                        db_cnt  <= '0;
                        level_q <= ~level_q;
                    end else begin
                        db_cnt <= db_cnt + 1'b1;
                    end
                end
            end
        end

        // A press always pulses rpt; repeat_en only decides whether the pulse train follows.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state  <= IDLE;
                rp_cnt <= '0;
                rpt_q  <= 1'b0;
            end else if (!bus.en) begin
                rpt_q <= 1'b0;
            end else begin
                rpt_q <= 1'b0;
                if (flip && level_q) begin
                    state  <= IDLE;
                    rp_cnt <= '0;
                end else if (flip) begin
                    rpt_q  <= 1'b1;
                    rp_cnt <= '0;
                    state  <= bus.repeat_en[ch] ? DELAY : IDLE;
                end else if (!bus.repeat_en[ch]) begin
                    state  <= IDLE;
                    rp_cnt <= '0;
                end else begin
                    case (state)
                        DELAY: begin
                            if (rp_cnt == RD_LAST) begin
                                rpt_q  <= 1'b1;
                                rp_cnt <= '0;
                                state  <= REPEAT;
                            end else begin
                                rp_cnt <= rp_cnt + 1'b1;
                            end
                        end
                        REPEAT: begin
                            if (rp_cnt == RR_LAST) begin
                                rpt_q  <= 1'b1;
                                rp_cnt <= '0;
                            end else begin
                                rp_cnt <= rp_cnt + 1'b1;
                            end
                        end
                        default: begin
                            state  <= IDLE;
                            rp_cnt <= '0;
                        end
                    endcase
                end
            end
        end

        assign bus.sig_o[ch] = level_q;
        assign bus.rise[ch]  = rise_q;
        assign bus.fall[ch]  = fall_q;
        assign bus.rpt[ch]   = rpt_q;
    end
endmodule
